// File: rtl/program_memory_arbiter.sv
// Single-port instruction RAM arbiter: boot loader streams words in,
// core fetch path reads them back once the FSM enters RUN.
module program_memory_arbiter #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000013,
    localparam int AW = $clog2(MEMORY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Boot_Load_i,
    input  logic                  Run_i,
    input  logic                  Load_Valid_i,
    input  logic [DATA_WIDTH-1:0] Load_Data_i,
    input  logic                  Load_Done_i,
    output logic                  Load_Ready_o,
    output logic [AW:0]           Load_Count_o,
    input  logic                  Fetch_Req_i,
    input  logic [DATA_WIDTH-1:0] Fetch_Address_i,
    output logic                  Fetch_Valid_o,
    output logic [DATA_WIDTH-1:0] Instruction_o,
    output logic                  Fetch_Error_o,
    output logic                  Cpu_Stall_o,
    output logic [1:0]            Mode_o,
    output logic                  Mem_We_o,
    output logic [AW-1:0]         Mem_Address_o,
    output logic [DATA_WIDTH-1:0] Mem_Wdata_o,
    input  logic [DATA_WIDTH-1:0] Mem_Rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-3:0] DEPTH_IDX = (DATA_WIDTH-2)'(MEMORY_DEPTH);

    state_t state;
    state_t next_state;

    logic [AW:0]           load_count;
    logic                  load_ready;
    logic                  load_write;
    logic [AW-1:0]         fetch_index;
    logic                  fetch_legal;
    logic                  fetch_accept;
    logic                  rsp_valid;
    logic                  rsp_hit;
    logic                  rsp_error;
    logic [DATA_WIDTH-1:0] instr_q;

    assign fetch_index  = Fetch_Address_i[AW+1:2];
    assign fetch_legal  = (Fetch_Address_i[1:0] == 2'b00) &&
                          (Fetch_Address_i[DATA_WIDTH-1:2] < DEPTH_IDX);
    assign load_ready   = (state == LOAD) && (load_count < DEPTH_CNT);
    assign load_write   = load_ready && Load_Valid_i;
    // A boot request steals the port, so a same-cycle fetch is dropped.
    assign fetch_accept = (state == RUN) && Fetch_Req_i && !Boot_Load_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (Boot_Load_i) begin
                    next_state = LOAD;
                end else if (Run_i) begin
                    next_state = RUN;
                end
            end
            LOAD: begin
                if (Load_Done_i || (load_count >= DEPTH_CNT)) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (Boot_Load_i) begin
                    next_state = LOAD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        Mode_o        = state;
        Cpu_Stall_o   = (state != RUN);
        Load_Ready_o  = load_ready;
        Mem_We_o      = 1'b0;
        Mem_Address_o = '0;
        Mem_Wdata_o   = Load_Data_i;
        unique case (state)
            LOAD: begin
                Mem_We_o      = load_write;
                Mem_Address_o = load_count[AW-1:0];
            end
            RUN: begin
                if (fetch_accept && fetch_legal) begin
                    Mem_Address_o = fetch_index;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count <= '0;
        end else if ((state != LOAD) && (next_state == LOAD)) begin
            load_count <= '0;
        end else if (load_write) begin
            load_count <= load_count + 1'b1;
        end
    end

    // instr_q remembers the last response so idle cycles hold Instruction_o.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_error <= 1'b0;
            instr_q   <= NOP_WORD;
        end else begin
            rsp_valid <= fetch_accept;
            rsp_hit   <= fetch_accept && fetch_legal;
            rsp_error <= fetch_accept && !fetch_legal;
            if (fetch_accept && !fetch_legal) begin
                instr_q <= NOP_WORD;
            end else if (rsp_hit) begin
                instr_q <= Mem_Rdata_i;
            end
        end
    end

    assign Load_Count_o  = load_count;
    assign Fetch_Valid_o = rsp_valid;
    assign Fetch_Error_o = rsp_error;
    assign Instruction_o = rsp_hit ? Mem_Rdata_i : instr_q;

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed + randomized bench for program_memory_arbiter with a
// behavioural RAM and a spec-level reference model.
module tb_program_memory_arbiter;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Boot_Load_i, Run_i, Load_Valid_i, Load_Done_i;
    logic [31:0] Load_Data_i;
    logic        Load_Ready_o;
    logic [5:0]  Load_Count_o;
    logic        Fetch_Req_i;
    logic [31:0] Fetch_Address_i;
    logic        Fetch_Valid_o;
    logic [31:0] Instruction_o;
    logic        Fetch_Error_o;
    logic        Cpu_Stall_o;
    logic [1:0]  Mode_o;
    logic        Mem_We_o;
    logic [4:0]  Mem_Address_o;
    logic [31:0] Mem_Wdata_o;
    logic [31:0] Mem_Rdata_i;

    program_memory_arbiter dut (
        .clk(clk), .reset(reset),
        .Boot_Load_i(Boot_Load_i), .Run_i(Run_i),
        .Load_Valid_i(Load_Valid_i), .Load_Data_i(Load_Data_i),
        .Load_Done_i(Load_Done_i), .Load_Ready_o(Load_Ready_o),
        .Load_Count_o(Load_Count_o), .Fetch_Req_i(Fetch_Req_i),
        .Fetch_Address_i(Fetch_Address_i), .Fetch_Valid_o(Fetch_Valid_o),
        .Instruction_o(Instruction_o), .Fetch_Error_o(Fetch_Error_o),
        .Cpu_Stall_o(Cpu_Stall_o), .Mode_o(Mode_o),
        .Mem_We_o(Mem_We_o), .Mem_Address_o(Mem_Address_o),
        .Mem_Wdata_o(Mem_Wdata_o), .Mem_Rdata_i(Mem_Rdata_i)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM: read data valid one cycle after address.
    logic [31:0] ram [32];
    always @(posedge clk) begin
        if (Mem_We_o) ram[Mem_Address_o] <= Mem_Wdata_o;
        Mem_Rdata_i <= ram[Mem_Address_o];
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 idle, 1 load, 2 run.
    int          m;
    int          cnt;
    logic [31:0] em [32];
    logic        pv, pe;
    logic [31:0] pi, last;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m = 0; cnt = 0; pv = 1'b0; pe = 1'b0; pi = NOP; last = NOP;
    endtask

    task automatic idle_inputs();
        Boot_Load_i = 0; Run_i = 0; Load_Valid_i = 0; Load_Data_i = 0;
        Load_Done_i = 0; Fetch_Req_i = 0; Fetch_Address_i = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_mode",  32'(Mode_o), 32'd0);
        chk("rst_stall", 32'(Cpu_Stall_o), 32'd1);
        chk("rst_count", 32'(Load_Count_o), 32'd0);
        chk("rst_fv",    32'(Fetch_Valid_o), 32'd0);
        chk("rst_ferr",  32'(Fetch_Error_o), 32'd0);
        chk("rst_instr", Instruction_o, NOP);
        chk("rst_we",    32'(Mem_We_o), 32'd0);
        chk("rst_addr",  32'(Mem_Address_o), 32'd0);
    endtask

    // Called just after a rising edge; applies one cycle of inputs.
    task automatic step(input logic boot, input logic run, input logic lv,
                        input logic [31:0] ld, input logic done,
                        input logic freq, input logic [31:0] fa);
        logic ready, we, legal, acc, full;
        logic [31:0] ei;
        Boot_Load_i = boot; Run_i = run; Load_Valid_i = lv;
        Load_Data_i = ld; Load_Done_i = done;
        Fetch_Req_i = freq; Fetch_Address_i = fa;
        ready = (m == 1) && (cnt < 32);
        we    = ready && lv;
        acc   = (m == 2) && freq && !boot;
        legal = acc && (fa[1:0] == 2'b00) && ((fa >> 2) < 32);
        full  = (m == 1) && (cnt >= 32);
        @(negedge clk);
        chk("mode",   32'(Mode_o), m[31:0]);
        chk("stall",  32'(Cpu_Stall_o), 32'(m != 2));
        chk("ready",  32'(Load_Ready_o), 32'(ready));
        chk("count",  32'(Load_Count_o), cnt[31:0]);
        chk("we",     32'(Mem_We_o), 32'(we));
        if (we) begin
            chk("waddr", 32'(Mem_Address_o), cnt[31:0]);
            chk("wdata", Mem_Wdata_o, ld);
        end
        if (legal) chk("raddr", 32'(Mem_Address_o), fa >> 2);
        chk("fvalid", 32'(Fetch_Valid_o), 32'(pv));
        chk("ferr",   32'(Fetch_Error_o), 32'(pv && pe));
        ei = pv ? pi : last;
        chk("instr",  Instruction_o, ei);
        if (pv) last = pi;
        pv = acc;
        pe = acc && !legal;
        pi = legal ? em[fa[6:2]] : NOP;
        if (we) begin
            em[cnt[4:0]] = ld;
            cnt++;
        end
        case (m)
            0: begin
                if (boot) begin m = 1; cnt = 0; end
                else if (run) m = 2;
            end
            1: if (done || full) m = 2;
            default: if (boot) begin m = 1; cnt = 0; end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic nop_step();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_word(input logic [31:0] w);
        step(0, 0, 1, w, 0, 0, 0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(0, 0, 0, 0, 0, 1, a);
    endtask

    logic [31:0] prog [4];
    logic [31:0] a;

    initial begin
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3; prog[3] = 32'h0000006F;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #12;
        check_reset_values();
        @(posedge clk); #1;
        reset = 1'b0;

        // Boot load of the four-word program, then Load_Done.
        nop_step();
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) load_word(prog[i]);
        step(0, 0, 0, 0, 1, 0, 0);
        nop_step();

        // Back-to-back legal fetches, then faulted ones.
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        nop_step();
        fetch(32'h2);
        fetch(32'h80);
        nop_step();
        nop_step();

        // Random fetches over the loaded region and out of range.
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 15));
            step(0, 0, 0, 0, 0, 1'($urandom_range(0, 3) != 0), a);
        end

        // Overfill: 33 words with no Load_Done.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 33; i++) load_word($urandom);
        nop_step();
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 31)) << 2;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a | 32'h100;
            step(0, 0, 0, 0, 0, 1'($urandom_range(0, 4) != 0), a);
        end

        // Boot request collides with a fetch; prior fetch still answers.
        fetch(32'h10);
        step(1, 0, 0, 0, 0, 1, 32'h14);
        nop_step();

        // Reset in the middle of a load, then a clean reload.
        load_word($urandom);
        load_word($urandom);
        idle_inputs();
        reset = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        nop_step();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) load_word($urandom);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) fetch(32'(i * 4));
        nop_step();
        nop_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_memory_arbiter.md
Name: program_memory_arbiter

Overview:
Owns the single port of the synchronous instruction RAM and shares it between two requesters:
- the boot loader, which streams program words in sequentially;
- the core fetch path, which reads instructions by byte address.
A 3-state mode FSM selects the owner and stalls the core while the program is loaded. Fetch-side alignment and range checking are done here, so the RAM only ever sees legal word indices.

Parameters:
MEMORY_DEPTH, 32, number of 32-bit words in the instruction RAM (AW = $clog2(MEMORY_DEPTH))
DATA_WIDTH, 32, instruction/word width
NOP_WORD, 32'h00000013, word returned on a faulted fetch

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
Boot_Load_i  input  1  request to enter LOAD mode
Run_i  input  1  request to leave IDLE and enter RUN
Load_Valid_i  input  1  loader word valid
Load_Data_i  input  DATA_WIDTH  loader word
Load_Done_i  input  1  loader finished, go to RUN
Load_Ready_o  output  1  loader word accepted this cycle when high with Load_Valid_i
Load_Count_o  output  AW+1  words written since LOAD entry
Fetch_Req_i  input  1  fetch request
Fetch_Address_i  input  DATA_WIDTH  fetch byte address
Fetch_Valid_o  output  1  fetch response valid
Instruction_o  output  DATA_WIDTH  fetched instruction
Fetch_Error_o  output  1  response is a faulted fetch
Cpu_Stall_o  output  1  core must hold its PC
Mode_o  output  2  00 IDLE, 01 LOAD, 10 RUN
Mem_We_o  output  1  RAM write enable
Mem_Address_o  output  AW  RAM word index
Mem_Wdata_o  output  DATA_WIDTH  RAM write data
Mem_Rdata_i  input  DATA_WIDTH  RAM read data, valid one cycle after address

Behaviour:
- Reset values (asynchronous): state IDLE, Mode_o=00, Cpu_Stall_o=1, Load_Count_o=0, Fetch_Valid_o=0, Fetch_Error_o=0, Instruction_o=NOP_WORD, Mem_We_o=0, Mem_Address_o=0.
- IDLE:
  - Boot_Load_i -> LOAD. Boot_Load_i wins over Run_i if both are high.
  - Run_i -> RUN.
- LOAD:
  - Load_Ready_o=1 while Load_Count_o < MEMORY_DEPTH.
  - On Load_Valid_i & Load_Ready_o: Mem_We_o=1, Mem_Address_o=Load_Count_o[AW-1:0], Mem_Wdata_o=Load_Data_i (combinational), Load_Count_o increments.
  - Load_Done_i -> RUN next cycle. A word presented in the same cycle is still written.
  - When Load_Count_o reaches MEMORY_DEPTH: Load_Ready_o=0, further words are not written, FSM moves to RUN automatically.
  - Fetch_Req_i is ignored.
- Entering LOAD from any state clears Load_Count_o to 0.
- RUN:
  - Cpu_Stall_o=0, Load_Ready_o=0, Mem_We_o=0.
  - Fetch word index = Fetch_Address_i >> 2.
  - Legal fetch: Fetch_Address_i[1:0]==0 and index < MEMORY_DEPTH. Mem_Address_o=index in request cycle N. Next cycle N+1: Fetch_Valid_o=1, Instruction_o=Mem_Rdata_i, Fetch_Error_o=0.
  - Illegal fetch: no RAM access. Next cycle: Fetch_Valid_o=1, Fetch_Error_o=1, Instruction_o=NOP_WORD.
  - Fully pipelined: one request accepted per cycle, fixed latency 1.
  - Cycles without a request give Fetch_Valid_o=0 and Instruction_o holds its last value.
  - Boot_Load_i -> LOAD. Boot_Load_i has priority over a same-cycle Fetch_Req_i, which is dropped (no response). A request accepted in the previous cycle still gets its response in the first LOAD cycle.
- Cpu_Stall_o=1 in IDLE and LOAD.
- Reset asserted mid-load: all state clears immediately. Words already written stay in RAM; the counter restarts at 0.

Test Plan:
1. Reset, then Boot_Load_i; stream 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F; then Load_Done_i -> Mem_We_o pulses at indices 0..3, Load_Count_o=4, Mode_o=10, Cpu_Stall_o=0.
2. RUN, back-to-back fetches at 0x0, 0x4, 0x8, 0xC -> Fetch_Valid_o high for 4 consecutive cycles, each one cycle after its request, with the loaded words in order.
3. Fetch at 0x2 and at 0x80 (DEPTH=32) -> Fetch_Error_o=1, Instruction_o=0x00000013, Mem_Address_o not driven to an out-of-range index.
4. LOAD 33 words without Load_Done_i -> 32 writes, Load_Ready_o drops after the 32nd, auto transition to RUN, 33rd word not written.
5. In RUN, Boot_Load_i and Fetch_Req_i in the same cycle, with a fetch issued the cycle before -> previous fetch still returns valid, new fetch gets no response, Mode_o=01, Load_Count_o=0.
6. Assert reset after 2 of 4 load words -> outputs at reset values immediately; re-load from index 0 succeeds.
